// File: rtl/fpcvt_pkg.sv
// Shared constants and state encoding for the float-to-linear converter.
package fpcvt_pkg;
   localparam int D_W   = 13;
   localparam int E_W   = 3;
   localparam int F_W   = 5;
   localparam int MAG_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/fp_to_lin_if.sv
// Handshake bundle: float input side and linear result side.
interface fp_to_lin_if
   import fpcvt_pkg::*;
();
   logic           in_valid;
   logic           in_ready;
   logic           S;
   logic [E_W-1:0] E;
   logic [F_W-1:0] F;
   logic           out_valid;
   logic           out_ready;
   logic [D_W-1:0] D;

   modport master (
      output in_valid, S, E, F, out_ready,
      input  in_ready, out_valid, D
   );

   modport slave (
      input  in_valid, S, E, F, out_ready,
      output in_ready, out_valid, D
   );
endinterface

// File: rtl/fp_to_lin.sv
// Converts a small sign/exponent/significand float to a two's
// complement integer by shifting one bit per cycle, then negating.
module fp_to_lin
   import fpcvt_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   fp_to_lin_if.slave  bus,
   output logic        busy
);

   state_t           state;
   state_t           state_nx;
   logic [MAG_W-1:0] mag;
   logic [E_W-1:0]   cnt;
   logic             sgn;
   logic [D_W-1:0]   d;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (bus.in_valid)  state_nx = SHIFT;
         SHIFT: if (cnt == '0)     state_nx = SIGN;
         SIGN:                     state_nx = DONE;
         DONE:  if (bus.out_ready) state_nx = IDLE;
         default:                  state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      busy          = (state != IDLE);
   end

   // Fields are captured only at accept; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         mag <= '0;
         cnt <= '0;
         sgn <= 1'b0;
         d   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mag <= MAG_W'(bus.F);
                  cnt <= bus.E;
                  sgn <= bus.S;
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  mag <= mag << 1;
                  cnt <= cnt - E_W'(1);
               end
            end
            SIGN: begin
               if (sgn) d <= ~{1'b0, mag} + D_W'(1);
               else     d <= {1'b0, mag};
            end
            default: ;
         endcase
      end
   end

   assign bus.D = d;

endmodule

// File: tb/tb_fp_to_lin.sv
// Randomized and directed checks of fp_to_lin against an arithmetic
// model of conversion result and handshake timing.
module tb_fp_to_lin;
   import fpcvt_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   fp_to_lin_if bus ();

   fp_to_lin dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [12:0] model_d(bit s, int e, int f);
      int m;
      m = f * (2 ** e);
      return s ? 13'(-m) : 13'(m);
   endfunction

   // Model: one conversion in flight; result due lat edges after accept.
   int          cyc = 0;
   bit          inflight = 0;
   int          acc = 0;
   int          lat = 0;
   logic [12:0] exp_d = '0;

   always @(posedge clk) begin
      if (rst) begin
         inflight = 0;
      end else if (!inflight && bus.in_valid) begin
         inflight = 1;
         acc      = cyc + 1;
         lat      = int'(bus.E) + 2;
         exp_d    = model_d(bus.S, int'(bus.E), int'(bus.F));
      end else if (inflight && (cyc - acc >= lat) && bus.out_ready) begin
         inflight = 0;
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      bit ev;
      if (cyc > 0) begin
         ev = inflight && (cyc - acc >= lat);
         chk("out_valid", 32'(bus.out_valid), 32'(ev));
         chk("in_ready", 32'(bus.in_ready), 32'(!inflight));
         chk("busy", 32'(busy), 32'(inflight));
         if (ev) chk("D", 32'(bus.D), 32'(exp_d));
      end
   end

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.S         = 1'b0;
      bus.E         = '0;
      bus.F         = '0;
   endtask

   // Accepts one float, scrambles inputs, returns edges to out_valid.
   task automatic start(bit s, int e, int f, output int n);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.S        = s;
      bus.E        = 3'(e);
      bus.F        = 5'(f);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.S        = 1'($urandom);
      bus.E        = 3'($urandom);
      bus.F        = 5'($urandom);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic finish_xfer();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic directed(string nm, bit s, int e, int f,
                           logic [12:0] d, int l);
      int n;
      start(s, e, f, n);
      chk({nm, "_lat"}, 32'(n), 32'(l));
      chk({nm, "_D"}, 32'(bus.D), 32'(d));
      finish_xfer();
   endtask

   initial begin
      int n;
      logic [12:0] held;
      idle_inputs();
      chk("model_22", 32'(model_d(0, 0, 22)), 32'd22);
      chk("model_3968", 32'(model_d(0, 7, 31)), 32'h0F80);
      chk("model_m160", 32'(model_d(1, 3, 20)), 32'h1F60);
      chk("model_negzero", 32'(model_d(1, 5, 0)), 32'h0000);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_D", 32'(bus.D), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      directed("e0f22", 0, 0, 22, 13'd22, 2);
      directed("e7f31", 0, 7, 31, 13'h0F80, 9);
      directed("neg160", 1, 3, 20, 13'h1F60, 5);
      directed("negzero", 1, 5, 0, 13'h0000, 7);
      directed("denorm", 0, 4, 3, 13'd48, 6);

      start(0, 2, 9, n);
      chk("hold_lat", 32'(n), 32'd4);
      held = bus.D;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'(i % 2 == 0);
         bus.E        = 3'($urandom);
         bus.F        = 5'($urandom);
         @(posedge clk);
         #1;
         chk("hold_D", 32'(bus.D), 32'(held));
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
      end
      chk("hold_value", 32'(held), 32'd36);
      bus.in_valid = 1'b0;
      finish_xfer();
      chk("hold_release_busy", 32'(busy), 32'd0);

      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.S        = 1'b1;
      bus.E        = 3'd6;
      bus.F        = 5'd17;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_D", 32'(bus.D), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      directed("after_abort", 0, 1, 16, 13'd32, 3);

      // Free-running random traffic judged by the model process.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid  = 1'($urandom_range(0, 2) == 0);
         bus.out_ready = 1'($urandom);
         bus.S         = 1'($urandom);
         bus.E         = 3'($urandom);
         bus.F         = 5'($urandom);
         if ($urandom_range(0, 400) == 0) rst = 1'b1;
         else                             rst = 1'b0;
      end
      @(posedge clk);
      #1;
      idle_inputs();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_to_lin.md
FP_TO_LIN -- requirements
Module: fp_to_lin

Interface
REQ-001 SHALL have clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have in_valid, input, 1 bit: S/E/F carry a float to convert.
REQ-004 SHALL have in_ready, output, 1 bit: block can accept a float this cycle.
REQ-005 SHALL have S, input, 1 bit: sign (1 = negative).
REQ-006 SHALL have E, input, 3 bits: exponent, unsigned 0..7.
REQ-007 SHALL have F, input, 5 bits: significand, unsigned 0..31.
REQ-008 SHALL have out_valid, output, 1 bit: D holds a completed result.
REQ-009 SHALL have out_ready, input, 1 bit: consumer takes D this cycle.
REQ-010 SHALL have D, output, 13 bits: two's-complement linear result.
REQ-011 SHALL have busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL compute magnitude = F * 2^E, in 12 bits unsigned; the maximum is 31*128 = 3968, so it never overflows.
REQ-013 SHALL output D = S ? -magnitude : magnitude, in 13-bit two's complement; S=1 with magnitude 0 SHALL give D=0.
REQ-014 SHALL implement four states: IDLE, SHIFT, SIGN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, latch mag<=zero-extended F, cnt<=E, sgn<=S, then go to SHIFT.
REQ-016 SHIFT: if cnt!=0, mag<=mag<<1 and cnt<=cnt-1, staying in SHIFT; if cnt==0, go to SIGN.
REQ-017 SIGN: D<=sgn ? (~{1'b0,mag}+1) : {1'b0,mag}, then go to DONE.
REQ-018 DONE: out_valid=1; D SHALL stay stable; on out_ready, go to IDLE.
REQ-019 Latency SHALL be E+2 cycles from the accept edge to out_valid high, independent of S and F.
REQ-020 in_ready SHALL be 0 in SHIFT, SIGN and DONE; in_valid there SHALL be ignored and SHALL NOT change state.
REQ-021 The accept and the out_ready handshakes SHALL NOT complete in the same cycle, because at most one transaction is in flight.
REQ-022 In DONE with out_ready low, D and out_valid SHALL hold indefinitely.
REQ-023 Non-normalized inputs (F[4]=0 with E>0) SHALL be converted literally per REQ-012, with no error flag.
REQ-024 S/E/F SHALL be sampled only on the accept edge; later changes SHALL NOT affect the result in flight.

Reset
REQ-025 On rst=1 at a clock edge, the state SHALL go to IDLE and D, mag, cnt, sgn and out_valid SHALL be cleared to 0; busy SHALL be 0 and in_ready SHALL be 1 from the next cycle.
REQ-026 Reset SHALL take priority over every handshake and SHALL abort any in-flight conversion without producing a result.

Structure
REQ-027 Shared package fpcvt_pkg SHALL hold the constants D_W=13, E_W=3, F_W=5 and MAG_W=12, plus the state enum.
REQ-028 The block SHALL be a single module with no sub-module; the shift/negate datapath SHALL stay inline.

Verification
REQ-029 S=0, E=0, F=22 -> out_valid 2 cycles after accept, D=13'd22.
REQ-030 S=0, E=7, F=31 -> out_valid 9 cycles after accept, D=13'h0F80 (3968).
REQ-031 S=1, E=3, F=20 -> out_valid 5 cycles after accept, D=13'h1F60 (-160).
REQ-032 S=1, E=5, F=0 -> D=13'h0000 (no negative zero).
REQ-033 Result in DONE with out_ready held low 4 cycles and in_valid pulsed -> D stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-034 rst asserted during SHIFT (E=6) -> next cycle IDLE, out_valid=0, D=0; a following S=0, E=1, F=16 -> D=13'd32.
